// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU definitions: opcodes, next-PC select encodings and fetch FSM states.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_REQ  = 2'b01,
    F_HALT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory req/rdy fetch channel between the fetch unit and imem.
interface fetch_pc_unit_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rdy;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Combinational next-PC select: sequential, branch, register-indirect and absolute jump.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs_data,
  input  logic [15:0]     i_imm16,
  input  logic [25:0]     i_jaddr,
  input  logic [1:0]      i_pcsrc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_next_pc
);

  logic [XLEN-1:0] w_br_off;

  assign o_pc_plus4 = i_pc + 32'd4;
  assign w_br_off   = {{14{i_imm16[15]}}, i_imm16, 2'b00};

  // Unknown select values (controller floating PCSrc) fall through to PC+4.
  always_comb begin
    o_next_pc = o_pc_plus4;
    case (i_pcsrc)
      PCSRC_SEQ: o_next_pc = o_pc_plus4;
      PCSRC_BR:  o_next_pc = o_pc_plus4 + w_br_off;
      PCSRC_JR:  o_next_pc = i_rs_data & 32'hFFFF_FFFC;
      PCSRC_J:   o_next_pc = {o_pc_plus4[XLEN-1:28], i_jaddr, 2'b00};
      default:   o_next_pc = o_pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, fetch FSM, one-word fetch buffer and instruction register
// for the multicycle CPU; decoded IR fields feed the controller and datapath.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]      HALT_OPCODE = OP_HALT
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             PCWre,
  input  logic             IRWre,
  input  logic [1:0]       PCSrc,
  input  logic [XLEN-1:0]  rs_data,
  fetch_pc_unit_if.master  imem,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  instr,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       sa,
  output logic [15:0]      imm16,
  output logic [25:0]      jaddr,
  output logic             fetch_busy,
  output logic             halted
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_fbuf;
  logic            r_fbuf_vld;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_pc_plus4;

  next_pc_calc u_next_pc_calc (
    .i_pc       (r_pc),
    .i_rs_data  (rs_data),
    .i_imm16    (r_instr[15:0]),
    .i_jaddr    (r_instr[25:0]),
    .i_pcsrc    (PCSrc),
    .o_pc_plus4 (w_pc_plus4),
    .o_next_pc  (w_next_pc)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state    <= F_REQ;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_fbuf     <= '0;
      r_fbuf_vld <= 1'b0;
    end else begin
      case (r_state)
        F_REQ: begin
          if (imem.imem_rdy) begin
            if (IRWre) begin
              r_instr <= imem.imem_rdata;
            end else begin
              r_fbuf     <= imem.imem_rdata;
              r_fbuf_vld <= 1'b1;
            end
            r_state <= F_IDLE;
          end
        end
        // A pending buffered word always drains first; halt outranks a PC advance.
        F_IDLE: begin
          if (r_fbuf_vld && IRWre) begin
            r_instr    <= r_fbuf;
            r_fbuf_vld <= 1'b0;
          end else if (!r_fbuf_vld && (r_instr[31:26] == HALT_OPCODE)) begin
            r_state <= F_HALT;
          end else if (PCWre) begin
            r_pc    <= w_next_pc;
            r_state <= F_REQ;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign imem.imem_req  = (r_state == F_REQ);
  assign imem.imem_addr = r_pc;

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign instr      = r_instr;
  assign opcode     = r_instr[31:26];
  assign rs         = r_instr[25:21];
  assign rt         = r_instr[20:16];
  assign rd         = r_instr[15:11];
  assign sa         = r_instr[10:6];
  assign imm16      = r_instr[15:0];
  assign jaddr      = r_instr[25:0];
  assign fetch_busy = (r_state == F_REQ) | r_fbuf_vld;
  assign halted     = (r_state == F_HALT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed next-PC table, fetch/buffer/halt/reset sequences,
// then random traffic against a queue-based reference model.
module tb_fetch_pc_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        PCWre = 1'b0;
  logic        IRWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] pc, pc_plus4, instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic        fetch_busy, halted;

  fetch_pc_unit_if imem ();

  fetch_pc_unit #(
    .RESET_PC    (32'h0000_0000),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .PCWre      (PCWre),
    .IRWre      (IRWre),
    .PCSrc      (PCSrc),
    .rs_data    (rs_data),
    .imem       (imem),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .sa         (sa),
    .imm16      (imm16),
    .jaddr      (jaddr),
    .fetch_busy (fetch_busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete the outstanding fetch with the given word.
  task automatic do_fetch(input logic [31:0] word, input logic irw);
    check("req_before_rdy", imem.imem_req, 1'b1);
    imem.imem_rdy   = 1'b1;
    imem.imem_rdata = word;
    IRWre           = irw;
    tick();
    imem.imem_rdy = 1'b0;
    IRWre         = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] target, input logic [31:0] word);
    PCSrc   = 2'b10;
    rs_data = target;
    PCWre   = 1'b1;
    tick();
    PCWre = 1'b0;
    do_fetch(word, 1'b1);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_ir;
  logic [31:0] m_buf[$];
  bit          m_wait, m_halt;

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ir,
                                           input logic [1:0] src, input logic [31:0] rsv);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = $signed(ir[15:0]);
    case (src)
      2'd1:    return seq + 32'(off * 4);
      2'd2:    return rsv & 32'hFFFF_FFFC;
      2'd3:    return (seq & 32'hF000_0000) | (32'(ir[25:0]) * 32'd4);
      default: return seq;
    endcase
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0;
    m_ir   = 32'h0;
    m_buf  = {};
    m_wait = 1'b1;
    m_halt = 1'b0;
  endtask

  task automatic model_step(input logic pcw, input logic irw, input logic [1:0] src,
                            input logic [31:0] rsv, input logic rdy, input logic [31:0] rdata);
    if (m_halt) return;
    if (m_wait) begin
      if (rdy) begin
        if (irw) m_ir = rdata;
        else m_buf.push_back(rdata);
        m_wait = 1'b0;
      end
    end else if (m_buf.size() > 0 && irw) begin
      m_ir = m_buf.pop_front();
    end else if (m_buf.size() == 0 && m_ir[31:26] == 6'h3f) begin
      m_halt = 1'b1;
    end else if (pcw) begin
      m_pc   = ref_next(m_pc, m_ir, src, rsv);
      m_wait = 1'b1;
    end
  endtask

  task automatic compare_model();
    logic [31:0] ir;
    ir = m_ir;
    check("rnd_pc",     pc,            m_pc);
    check("rnd_addr",   imem.imem_addr, m_pc);
    check("rnd_pc4",    pc_plus4,      m_pc + 32'd4);
    check("rnd_instr",  instr,         ir);
    check("rnd_fields", {opcode, rs, rt, rd, sa, imm16, jaddr}, {ir[31:6], ir[15:0], ir[25:0]});
    check("rnd_req",    imem.imem_req, m_wait && !m_halt);
    check("rnd_busy",   fetch_busy,    m_wait || (m_buf.size() > 0));
    check("rnd_halted", halted,        m_halt);
  endtask

  // ---------------- directed next-PC table ----------------
  typedef struct {
    logic [31:0] base;
    logic [31:0] word;
    logic [1:0]  src;
    logic [31:0] rsv;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, exp_pc;

    vecs[0] = '{32'h0000_0010, 32'h0000_FFFF, 2'b01, 32'h0,         32'h0000_0010};
    vecs[1] = '{32'h0000_0010, 32'h0000_0003, 2'b01, 32'h0,         32'h0000_0020};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 2'b10, 32'h0000_1003, 32'h0000_1000};
    vecs[3] = '{32'hF000_0000, 32'h0800_0001, 2'b11, 32'h0,         32'hF000_0004};
    vecs[4] = '{32'h0000_0100, 32'h0000_0000, 2'b00, 32'h0,         32'h0000_0104};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b00, 32'h0,         32'h0000_0000};
    vecs[6] = '{32'h0000_0008, 32'h0000_8000, 2'b01, 32'h0,         32'hFFFE_000C};
    vecs[7] = '{32'h7FFF_FFFC, 32'h0000_7FFF, 2'b01, 32'h0,         32'h8001_FFFC};
    vecs[8] = '{32'h1234_5670, 32'h0BFF_FFFF, 2'b11, 32'h0,         32'h1FFF_FFFC};
    vecs[9] = '{32'hEFFF_FFFC, 32'h0800_0010, 2'b11, 32'h0,         32'hF000_0040};

    imem.imem_rdy   = 1'b0;
    imem.imem_rdata = '0;

    // Reset values, then a fetch answered after a 2-cycle wait.
    tick();
    check("rst_pc",     pc,             32'h0);
    check("rst_instr",  instr,          32'h0);
    check("rst_req",    imem.imem_req,  1'b1);
    check("rst_addr",   imem.imem_addr, 32'h0);
    check("rst_halted", halted,         1'b0);
    check("rst_busy",   fetch_busy,     1'b1);
    RST = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      check("first_req_held", imem.imem_req, 1'b1);
      imem.imem_rdy   = (i == 2);
      imem.imem_rdata = 32'h0800_0005;
      IRWre           = 1'b1;
      tick();
    end
    imem.imem_rdy = 1'b0;
    IRWre         = 1'b0;
    check("first_instr", instr,         32'h0800_0005);
    check("first_pc",    pc,            32'h0);
    check("first_busy",  fetch_busy,    1'b0);
    check("first_req",   imem.imem_req, 1'b0);

    // Next-PC table.
    foreach (vecs[i]) begin
      jump_to(vecs[i].base, vecs[i].word);
      check("vec_base", pc,    vecs[i].base);
      check("vec_ir",   instr, vecs[i].word);
      PCSrc   = vecs[i].src;
      rs_data = vecs[i].rsv;
      PCWre   = 1'b1;
      tick();
      PCWre = 1'b0;
      check("vec_pc",   pc,             vecs[i].exp);
      check("vec_addr", imem.imem_addr, vecs[i].exp);
      check("vec_pc4",  pc_plus4,       vecs[i].exp + 32'd4);
      check("vec_req",  imem.imem_req,  1'b1);
      do_fetch(32'h0, 1'b1);
    end

    // Word arrives with IRWre=0: buffered, then loaded while PCWre is ignored.
    exp_pc = vecs[9].exp + 32'd4;
    PCSrc  = 2'b00;
    PCWre  = 1'b1;
    tick();
    PCWre = 1'b0;
    check("buf_pc_adv", pc, exp_pc);
    w = 32'h1234_5678;
    do_fetch(w, 1'b0);
    check("buf_instr_hold", instr,         32'h0);
    check("buf_busy",       fetch_busy,    1'b1);
    check("buf_req",        imem.imem_req, 1'b0);
    IRWre = 1'b1;
    PCWre = 1'b1;
    tick();
    IRWre = 1'b0;
    PCWre = 1'b0;
    check("buf_instr_load", instr,         w);
    check("buf_pc_kept",    pc,            exp_pc);
    check("buf_busy_clr",   fetch_busy,    1'b0);
    check("buf_no_req",     imem.imem_req, 1'b0);

    // Halt opcode freezes fetch until reset.
    exp_pc = exp_pc + 32'd4;
    PCWre  = 1'b1;
    tick();
    PCWre = 1'b0;
    do_fetch(32'hFC00_0000, 1'b1);
    check("halt_not_yet", halted, 1'b0);
    tick();
    check("halt_set", halted, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      PCWre         = 1'b1;
      IRWre         = 1'b1;
      PCSrc         = 2'b10;
      rs_data       = 32'h0000_0800;
      imem.imem_rdy = 1'b1;
      tick();
    end
    PCWre         = 1'b0;
    IRWre         = 1'b0;
    imem.imem_rdy = 1'b0;
    check("halt_pc_frozen", pc,            exp_pc);
    check("halt_ir_frozen", instr,         32'hFC00_0000);
    check("halt_no_req",    imem.imem_req, 1'b0);
    check("halt_busy",      fetch_busy,    1'b0);
    RST = 1'b0;
    #1;
    check("halt_rst_pc",  pc,     32'h0);
    check("halt_rst_hlt", halted, 1'b0);
    tick();
    RST = 1'b1;
    do_fetch(32'h0, 1'b1);

    // Reset asserted mid-fetch at pc=0x40.
    PCSrc   = 2'b10;
    rs_data = 32'h0000_0040;
    PCWre   = 1'b1;
    tick();
    PCWre = 1'b0;
    check("mid_addr", imem.imem_addr, 32'h40);
    check("mid_req",  imem.imem_req,  1'b1);
    RST = 1'b0;
    #1;
    check("mid_rst_pc",   pc,             32'h0);
    check("mid_rst_addr", imem.imem_addr, 32'h0);
    check("mid_rst_req",  imem.imem_req,  1'b1);
    tick();
    RST = 1'b1;
    do_fetch(32'h2000_0007, 1'b1);
    check("mid_refetch_ir", instr, 32'h2000_0007);
    check("mid_refetch_pc", pc,    32'h0);

    // Random traffic against the reference model.
    RST = 1'b0;
    #1;
    model_reset();
    compare_model();
    tick();
    RST = 1'b1;
    for (int unsigned cyc = 0; cyc < 600; cyc++) begin
      PCWre   = ($urandom % 3 == 0) && (m_buf.size() == 0);
      IRWre   = $urandom % 2;
      PCSrc   = 2'($urandom);
      rs_data = $urandom;
      w       = $urandom;
      if ($urandom % 16 == 0) w[31:26] = 6'h3f;
      else if (w[31:26] == 6'h3f) w[31:26] = 6'h00;
      imem.imem_rdata = w;
      imem.imem_rdy   = m_wait && !m_halt && ($urandom % 2 == 1);
      model_step(PCWre, IRWre, PCSrc, rs_data, imem.imem_rdy, w);
      tick();
      compare_model();
      if ((m_halt && $urandom % 4 == 0) || ($urandom % 64 == 0)) begin
        RST = 1'b0;
        #1;
        model_reset();
        compare_model();
        tick();
        RST = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
